muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage of the 5-stage core. It accepts one M-extension operation at a time from the ID/EX register and computes it over multiple cycles. While it works, it raises mul_stall to the hazard unit, which freezes IF and ID. It returns the 32-bit result to the EX result mux in the cycle the stall drops.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_iter_core.sv | 61 ++++++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_BY_ZERO_Q    = 32'hFFFF_FFFF;
  localparam int          MULDIV_STEPS     = 32;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one step per cycle.
// acc holds {hi, lo}: product after 32 multiply steps, {remainder, quotient} after 32 divide steps.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        div_q, div_d;
  logic [32:0] sum_s;
  logic [32:0] trial_s;

  // Next accumulator: load operands, or advance one multiply/divide step.
  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    div_d   = div_q;
    sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    trial_s = acc_q[63:31] - {1'b0, b_q};
    if (load) begin
      acc_d = {32'd0, a};
      b_d   = b;
      div_d = is_div;
    end else if (step) begin
      if (div_q) begin
        if (!trial_s[32]) begin
          acc_d = {trial_s[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {acc_q[62:0], 1'b0};
        end
      end else begin
        acc_d = {sum_s, acc_q[31:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 64'd0;
      b_q   <= 32'd0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: sign handling, control FSM and pipeline stall around
// the unsigned iterative core. Division corner cases bypass the core entirely.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            mul_stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d, op_in_s;
  logic [4:0]    count_q, count_d;
  logic          neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic          fast_q, fast_d;
  logic [31:0]   fast_res_q, fast_res_d;
  logic          a_neg_s, b_neg_s, div_zero_s, div_ovf_s;
  logic [31:0]   mag_a_s, mag_b_s, fix_res_s;
  logic [63:0]   acc_s, prod_s;
  logic          core_load_s, core_step_s;

  // Operand decode, magnitudes and fast-path detection for the incoming request.
  always_comb begin
    op_in_s    = muldiv_op_e'(op);
    a_neg_s    = op_a_signed(op_in_s) & rs1_val[31];
    b_neg_s    = op_b_signed(op_in_s) & rs2_val[31];
    mag_a_s    = a_neg_s ? (32'd0 - rs1_val) : rs1_val;
    mag_b_s    = b_neg_s ? (32'd0 - rs2_val) : rs2_val;
    div_zero_s = op_is_div(op_in_s) & (rs2_val == 32'd0);
    div_ovf_s  = ((op_in_s == OP_DIV) | (op_in_s == OP_REM)) &
                 (rs1_val == DIV_OVF_DIVIDEND) & (rs2_val == 32'hFFFF_FFFF);
  end

  // Control FSM; a dropped req mid-operation is handled like kill.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    fast_d      = fast_q;
    fast_res_d  = fast_res_q;
    core_load_s = 1'b0;
    core_step_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !kill) begin
          op_d    = op_in_s;
          neg_a_d = a_neg_s;
          neg_b_d = b_neg_s;
          count_d = 5'd0;
          if (div_zero_s || div_ovf_s) begin
            fast_d = 1'b1;
            if (op_is_rem(op_in_s)) begin
              fast_res_d = div_zero_s ? rs1_val : 32'd0;
            end else begin
              fast_res_d = div_zero_s ? DIV_BY_ZERO_Q : DIV_OVF_DIVIDEND;
            end
            state_d = DONE;
          end else begin
            fast_d      = 1'b0;
            core_load_s = 1'b1;
            state_d     = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (kill || !req) begin
          state_d = IDLE;
          count_d = 5'd0;
        end else begin
          core_step_s = 1'b1;
          count_d     = count_q + 5'd1;
          if (count_q == 5'(MULDIV_STEPS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = 5'd0;
      end
      default: begin
        state_d = IDLE;
        count_d = 5'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      op_q       <= OP_MUL;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
    end
  end

  muldiv_iter_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load_s),
    .step   (core_step_s),
    .is_div (op_is_div(op_in_s)),
    .a      (mag_a_s),
    .b      (mag_b_s),
    .acc    (acc_s)
  );

  // Sign fix-up and result-half selection from the finished magnitudes.
  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_s) : acc_s;
    case (op_q)
      OP_MUL:                       fix_res_s = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[63:32];
      OP_DIV, OP_DIVU:              fix_res_s = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_s[31:0]) : acc_s[31:0];
      OP_REM, OP_REMU:              fix_res_s = neg_a_q ? (32'd0 - acc_s[63:32]) : acc_s[63:32];
      default:                      fix_res_s = 32'd0;
    endcase
  end

  assign mul_stall    = req & ~kill & (state_q != DONE);
  assign result_valid = (state_q == DONE) & ~kill;
  assign result       = result_valid ? (fast_q ? fast_res_q : fix_res_s) : 32'd0;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic        mul_stall;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .kill         (kill),
    .op           (op),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .mul_stall    (mul_stall),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      3'd0: begin ps = sa * sb; p = ps; return p[31:0]; end
      3'd1: begin ps = sa * sb; p = ps; return p[63:32]; end
      3'd2: begin ps = sa * longint'(ub); p = ps; return p[63:32]; end
      3'd3: begin pu = ua * ub; p = pu; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb; p = ps; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        ps = sa % sb; p = ps; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          stall_n, vld_n, vld_cyc, exp_lat;
    logic [31:0] res;
    stall_n = 0; vld_n = 0; vld_cyc = -1; res = 32'd0;
    exp_lat = is_fast(o, a, b) ? 1 : 33;
    op = o; rs1_val = a; rs2_val = b; req = 1'b1;
    for (int c = 0; c < 45 && vld_n == 0; c++) begin
      @(negedge clk);
      if (mul_stall) stall_n++;
      if (result_valid) begin vld_n++; vld_cyc = c; res = result; end
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(negedge clk);
    if (result_valid) vld_n++;
    check_val({tag, " result"}, {32'd0, res}, {32'd0, ref_model(o, a, b)});
    check_val({tag, " latency"}, 64'(vld_cyc), 64'(exp_lat));
    check_val({tag, " stall_cycles"}, 64'(stall_n), 64'(exp_lat));
    check_val({tag, " valid_pulses"}, 64'(vld_n), 64'd1);
    check_val({tag, " idle_after"}, {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #12;
    check_val("reset busy", {63'd0, busy}, 64'd0);
    check_val("reset valid", {63'd0, result_valid}, 64'd0);
    check_val("reset result", {32'd0, result}, 64'd0);
    check_val("reset stall", {63'd0, mul_stall}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op("MULH", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("MULHSU", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("MULHU", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("DIVU", 3'd5, 32'hFFFF_FFFF, 32'd16);
    run_op("REMU", 3'd7, 32'hFFFF_FFFF, 32'd16);
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // kill during BUSY at count 10 (cycle 11 after the request)
    op = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; req = 1'b1;
    for (int c = 0; c < 11; c++) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(negedge clk);
    check_val("kill stall", {63'd0, mul_stall}, 64'd0);
    check_val("kill valid", {63'd0, result_valid}, 64'd0);
    @(posedge clk); #1;
    kill = 1'b0; req = 1'b0;
    begin
      int vld_seen;
      vld_seen = 0;
      @(negedge clk);
      check_val("kill busy", {63'd0, busy}, 64'd0);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (result_valid) vld_seen++;
      end
      check_val("kill no_result", 64'(vld_seen), 64'd0);
    end
    @(posedge clk); #1;
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7);

    // reset pulse mid-BUSY
    op = 3'd0; rs1_val = 32'd123; rs2_val = 32'd456; req = 1'b1;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check_val("rst busy", {63'd0, busy}, 64'd0);
    check_val("rst valid", {63'd0, result_valid}, 64'd0);
    check_val("rst result", {32'd0, result}, 64'd0);
    req = 1'b0; #1;
    check_val("rst stall", {63'd0, mul_stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("MUL 3*4", 3'd0, 32'd3, 32'd4);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
